// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register file access controller.
//   - Width limits of the 32x32 register file (index limits, width = limit + 1).
//   - Command opcodes carried on cmd_op.
//   - FSM state encoding used by regfile_access_ctrl.
package regfile_access_ctrl_pkg;

    localparam int unsigned DATA_INDEX_LIMIT     = 31;
    localparam int unsigned REG_ADDR_INDEX_LIMIT = 4;

    localparam logic [1:0] RFC_OP_READ  = 2'b01;
    localparam logic [1:0] RFC_OP_WRITE = 2'b10;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StWr   = 3'd2,
        StErr  = 3'd3,
        StRsp  = 3'd4
    } rfc_state_e;

endpackage

// File: rtl/rfc_rsp_hold.sv
// Response holding register for the register file access controller.
// Captures a response payload on load and presents it with rsp_valid until the
// consumer takes it (rsp_valid & rsp_ready); the handshake clears the whole payload.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load                    capture load_* into the response register
//   load_is_wr, load_err    response kind / illegal-command flag
//   load_opnd1, load_opnd2  operand payload
//   rsp_ready               consumer ready
//   rsp_valid               response held
//   rsp_is_wr, rsp_err      held flags
//   rsp_opnd1, rsp_opnd2    held operands
//   rsp_fire                handshake completes this cycle
module rfc_rsp_hold
    import regfile_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_INDEX_LIMIT + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  load_is_wr,
    input  logic                  load_err,
    input  logic [DATA_WIDTH-1:0] load_opnd1,
    input  logic [DATA_WIDTH-1:0] load_opnd2,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic                  rsp_is_wr,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_opnd1,
    output logic [DATA_WIDTH-1:0] rsp_opnd2,
    output logic                  rsp_fire
);

    assign rsp_fire = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_is_wr <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_opnd1 <= '0;
            rsp_opnd2 <= '0;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
            rsp_is_wr <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_opnd1 <= '0;
            rsp_opnd2 <= '0;
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_is_wr <= load_is_wr;
            rsp_err   <= load_err;
            rsp_opnd1 <= load_opnd1;
            rsp_opnd2 <= load_opnd2;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator side of the 32x32 dual-read register file port.
// Accepts READ_OPND / WRITE_BACK commands over cmd_valid/cmd_ready, issues exactly one
// register file strobe cycle (never READ and WRITE together), then returns the result
// over a held rsp_valid/rsp_ready handshake. Flow: IDLE -> RD | WR | ERR -> RSP -> IDLE.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid, cmd_ready, cmd_op       command handshake and opcode (01 read, 10 write)
//   cmd_rs, cmd_rt, cmd_rd, cmd_wdata  command addresses and write data
//   rsp_valid, rsp_ready               response handshake
//   rsp_is_wr, rsp_err                 write completion / illegal opcode flags
//   rsp_opnd1, rsp_opnd2               operand values (0 for non-read responses)
//   rf_read, rf_write                  register file strobes (registered)
//   rf_addr_r1, rf_addr_r2, rf_addr_w  register file addresses (0 when strobe is 0)
//   rf_data_w                          register file write data (0 when rf_write is 0)
//   rf_data_r1, rf_data_r2             register file read data
//   txn_count                          completed responses, wraps
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_INDEX_LIMIT + 1,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_INDEX_LIMIT + 1,
    parameter bit          ZERO_PROT  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rs,
    input  logic [ADDR_WIDTH-1:0] cmd_rt,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_is_wr,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_opnd1,
    output logic [DATA_WIDTH-1:0] rsp_opnd2,
    output logic                  rf_read,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2,
    output logic [ADDR_WIDTH-1:0] rf_addr_w,
    output logic [DATA_WIDTH-1:0] rf_data_w,
    input  logic [DATA_WIDTH-1:0] rf_data_r1,
    input  logic [DATA_WIDTH-1:0] rf_data_r2,
    output logic [15:0]           txn_count
);

    rfc_state_e            state_q;
    logic                  cmd_ready_q;
    logic                  rf_read_q;
    logic                  rf_write_q;
    logic [ADDR_WIDTH-1:0] rs_q;
    logic [ADDR_WIDTH-1:0] rt_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [15:0]           txn_count_q;

    logic                  cmd_accept;
    logic                  wr_allowed;
    logic                  rsp_load;
    logic                  rsp_load_is_wr;
    logic                  rsp_load_err;
    logic [DATA_WIDTH-1:0] rsp_load_opnd1;
    logic [DATA_WIDTH-1:0] rsp_load_opnd2;
    logic                  rsp_fire;

    assign cmd_accept = cmd_ready_q & cmd_valid;
    // A protected r0 write still runs the WR cycle, just without the strobe.
    assign wr_allowed = !(ZERO_PROT && (cmd_rd == '0));

    // Addresses/data are gated by their strobe so the bus idles at zero.
    assign cmd_ready  = cmd_ready_q;
    assign rf_read    = rf_read_q;
    assign rf_write   = rf_write_q;
    assign rf_addr_r1 = rf_read_q  ? rs_q    : '0;
    assign rf_addr_r2 = rf_read_q  ? rt_q    : '0;
    assign rf_addr_w  = rf_write_q ? rd_q    : '0;
    assign rf_data_w  = rf_write_q ? wdata_q : '0;
    assign txn_count  = txn_count_q;

    // Response payload is loaded at the edge that ends the strobe cycle.
    always_comb begin
        rsp_load       = 1'b0;
        rsp_load_is_wr = 1'b0;
        rsp_load_err   = 1'b0;
        rsp_load_opnd1 = '0;
        rsp_load_opnd2 = '0;
        unique case (state_q)
            StRd: begin
                rsp_load       = 1'b1;
                rsp_load_opnd1 = (ZERO_PROT && (rs_q == '0)) ? '0 : rf_data_r1;
                rsp_load_opnd2 = (ZERO_PROT && (rt_q == '0)) ? '0 : rf_data_r2;
            end
            StWr: begin
                rsp_load       = 1'b1;
                rsp_load_is_wr = 1'b1;
            end
            StErr: begin
                rsp_load     = 1'b1;
                rsp_load_err = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            rf_read_q   <= 1'b0;
            rf_write_q  <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            wdata_q     <= '0;
            txn_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_accept) begin
                        cmd_ready_q <= 1'b0;
                        rs_q        <= cmd_rs;
                        rt_q        <= cmd_rt;
                        rd_q        <= cmd_rd;
                        wdata_q     <= cmd_wdata;
                        case (cmd_op)
                            RFC_OP_READ: begin
                                state_q   <= StRd;
                                rf_read_q <= 1'b1;
                            end
                            RFC_OP_WRITE: begin
                                state_q    <= StWr;
                                rf_write_q <= wr_allowed;
                            end
                            default: state_q <= StErr;
                        endcase
                    end else begin
                        // Raises ready in the first cycle after reset release.
                        cmd_ready_q <= 1'b1;
                    end
                end
                StRd: begin
                    rf_read_q <= 1'b0;
                    state_q   <= StRsp;
                end
                StWr: begin
                    rf_write_q <= 1'b0;
                    state_q    <= StRsp;
                end
                StErr: begin
                    state_q <= StRsp;
                end
                StRsp: begin
                    if (rsp_fire) begin
                        txn_count_q <= txn_count_q + 16'd1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b0;
                    rf_read_q   <= 1'b0;
                    rf_write_q  <= 1'b0;
                end
            endcase
        end
    end

    rfc_rsp_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (rsp_load),
        .load_is_wr (rsp_load_is_wr),
        .load_err   (rsp_load_err),
        .load_opnd1 (rsp_load_opnd1),
        .load_opnd2 (rsp_load_opnd2),
        .rsp_ready  (rsp_ready),
        .rsp_valid  (rsp_valid),
        .rsp_is_wr  (rsp_is_wr),
        .rsp_err    (rsp_err),
        .rsp_opnd1  (rsp_opnd1),
        .rsp_opnd2  (rsp_opnd2),
        .rsp_fire   (rsp_fire)
    );

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural 32x32 register file
// (combinational read while READ is high, write on the clock edge while WRITE is high).
module tb_regfile_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_rs = '0;
    logic [AW-1:0] cmd_rt = '0;
    logic [AW-1:0] cmd_rd = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_is_wr;
    logic          rsp_err;
    logic [DW-1:0] rsp_opnd1;
    logic [DW-1:0] rsp_opnd2;
    logic          rf_read;
    logic          rf_write;
    logic [AW-1:0] rf_addr_r1;
    logic [AW-1:0] rf_addr_r2;
    logic [AW-1:0] rf_addr_w;
    logic [DW-1:0] rf_data_w;
    logic [DW-1:0] rf_data_r1;
    logic [DW-1:0] rf_data_r2;
    logic [15:0]   txn_count;

    logic [DW-1:0] mem [32];

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;
    int overlap = 0;
    int n_fires = 0;
    int acc_q[$];
    logic [DW-1:0] last_opnd1 = '0;
    logic [DW-1:0] last_opnd2 = '0;

    regfile_access_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_is_wr  (rsp_is_wr),
        .rsp_err    (rsp_err),
        .rsp_opnd1  (rsp_opnd1),
        .rsp_opnd2  (rsp_opnd2),
        .rf_read    (rf_read),
        .rf_write   (rf_write),
        .rf_addr_r1 (rf_addr_r1),
        .rf_addr_r2 (rf_addr_r2),
        .rf_addr_w  (rf_addr_w),
        .rf_data_w  (rf_data_w),
        .rf_data_r1 (rf_data_r1),
        .rf_data_r2 (rf_data_r2),
        .txn_count  (txn_count)
    );

    always #5 clk = ~clk;

    // Register file model; seeded with A000_00nn so r0 holds a non-zero value.
    assign rf_data_r1 = rf_read ? mem[rf_addr_r1] : '0;
    assign rf_data_r2 = rf_read ? mem[rf_addr_r2] : '0;

    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (rf_write) begin
            mem[rf_addr_w] <= rf_data_w;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_read) rd_pulses <= rd_pulses + 1;
        if (rf_write) wr_pulses <= wr_pulses + 1;
        if (rf_read && rf_write) overlap <= overlap + 1;
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (rsp_valid && rsp_ready) begin
            n_fires <= n_fires + 1;
            last_opnd1 <= rsp_opnd1;
            last_opnd2 <= rsp_opnd2;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns one cycle after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic [DW-1:0] wd);
        int n = 0;
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for a response, consumes it and returns at the following negedge.
    task automatic get_rsp(output logic is_wr, output logic err, output logic [DW-1:0] o1,
                           output logic [DW-1:0] o2, output int lat);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("rsp_timeout", 32'(n), 32'd0);
        is_wr = rsp_is_wr; err = rsp_err; o1 = rsp_opnd1; o2 = rsp_opnd2; lat = n;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic          w, e;
        logic [DW-1:0] o1, o2;
        int            lat, base_rd, base_wr, base_acc, base_fire;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_rf_strobes", {30'd0, rf_read, rf_write}, 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_txn", 32'(txn_count), 32'd0);
        seed = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write r5 then read it back
        base_wr = wr_pulses;
        send(2'b10, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
        get_rsp(w, e, o1, o2, lat);
        check_eq("wr_latency", 32'(lat), 32'd1);
        check_eq("wr_is_wr", 32'(w), 32'd1);
        check_eq("wr_err", 32'(e), 32'd0);
        check_eq("wr_opnd1", o1, 32'd0);
        check_eq("wr_pulses", 32'(wr_pulses - base_wr), 32'd1);
        check_eq("wr_mem5", mem[5], 32'hDEAD_BEEF);
        send(2'b01, 5'd5, 5'd0, 5'd0, 32'd0);
        get_rsp(w, e, o1, o2, lat);
        check_eq("raw_is_wr", 32'(w), 32'd0);
        check_eq("raw_opnd1", o1, 32'hDEAD_BEEF);
        check_eq("raw_opnd2_r0", o2, 32'd0);
        check_eq("raw_txn", 32'(txn_count), 32'd2);

        // Protected r0 write
        base_wr = wr_pulses;
        send(2'b10, 5'd0, 5'd0, 5'd0, 32'h1234_5678);
        get_rsp(w, e, o1, o2, lat);
        check_eq("r0w_is_wr", 32'(w), 32'd1);
        check_eq("r0w_err", 32'(e), 32'd0);
        check_eq("r0w_no_strobe", 32'(wr_pulses - base_wr), 32'd0);
        check_eq("r0w_mem0", mem[0], 32'hA000_0000);
        send(2'b01, 5'd0, 5'd5, 5'd0, 32'd0);
        get_rsp(w, e, o1, o2, lat);
        check_eq("r0r_opnd1", o1, 32'd0);
        check_eq("r0r_opnd2", o2, 32'hDEAD_BEEF);
        check_eq("r0_txn", 32'(txn_count), 32'd4);

        // Illegal opcodes
        base_rd = rd_pulses;
        base_wr = wr_pulses;
        send(2'b11, 5'd3, 5'd4, 5'd6, 32'h5555_5555);
        get_rsp(w, e, o1, o2, lat);
        check_eq("err11_err", 32'(e), 32'd1);
        check_eq("err11_is_wr", 32'(w), 32'd0);
        check_eq("err11_opnd1", o1, 32'd0);
        send(2'b00, 5'd3, 5'd4, 5'd6, 32'h5555_5555);
        get_rsp(w, e, o1, o2, lat);
        check_eq("err00_err", 32'(e), 32'd1);
        check_eq("err_no_strobes", 32'(rd_pulses - base_rd + wr_pulses - base_wr), 32'd0);
        check_eq("err_mem6", mem[6], 32'hA000_0006);
        check_eq("err_txn", 32'(txn_count), 32'd6);

        // Back-pressure: response held for 10 cycles, new command ignored meanwhile
        send(2'b01, 5'd3, 5'd7, 5'd0, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        base_rd = rd_pulses;
        base_wr = wr_pulses;
        cmd_op = 2'b10; cmd_rd = 5'd9; cmd_wdata = 32'h0000_FFFF; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("hold_valid_%0d", i), 32'(rsp_valid), 32'd1);
            check_eq($sformatf("hold_opnd1_%0d", i), rsp_opnd1, 32'hA000_0003);
            check_eq($sformatf("hold_cmd_ready_%0d", i), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check_eq("hold_no_strobe", 32'(rd_pulses - base_rd + wr_pulses - base_wr), 32'd0);
        get_rsp(w, e, o1, o2, lat);
        check_eq("hold_opnd1", o1, 32'hA000_0003);
        check_eq("hold_opnd2", o2, 32'hA000_0007);
        check_eq("hold_mem9", mem[9], 32'hA000_0009);
        check_eq("hold_txn", 32'(txn_count), 32'd7);

        // Back-to-back reads: 12 cycles with valid and ready held -> 4 accepts, 3 apart
        base_acc = acc_q.size();
        base_fire = n_fires;
        cmd_op = 2'b01; cmd_rs = 5'd1; cmd_rt = 5'd2;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("b2b_accepts", 32'(acc_q.size() - base_acc), 32'd4);
        if (acc_q.size() - base_acc >= 3) begin
            check_eq("b2b_gap0", 32'(acc_q[base_acc + 1] - acc_q[base_acc]), 32'd3);
            check_eq("b2b_gap1", 32'(acc_q[base_acc + 2] - acc_q[base_acc + 1]), 32'd3);
        end
        check_eq("b2b_fires", 32'(n_fires - base_fire), 32'd4);
        check_eq("b2b_opnd1", last_opnd1, 32'hA000_0001);
        check_eq("b2b_opnd2", last_opnd2, 32'hA000_0002);
        check_eq("b2b_txn", 32'(txn_count), 32'd11);
        check_eq("no_overlap", 32'(overlap), 32'd0);

        // Asynchronous reset in the middle of RD
        send(2'b01, 5'd4, 5'd8, 5'd0, 32'd0);
        check_eq("midrd_read", 32'(rf_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrd_rf_read", 32'(rf_read), 32'd0);
        check_eq("midrd_addr_r1", 32'(rf_addr_r1), 32'd0);
        check_eq("midrd_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("midrd_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrd_txn", 32'(txn_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("post_txn", 32'(txn_count), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
